dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Blocking, direct-mapped, write-through, no-write-allocate data cache that answers the `dcache_*` requests issued by the memory/writeback stage and stalls the pipeline on misses and stores. It sits between the core's data-memory port and a single-outstanding main-memory request/response port. Read hits return data one cycle after the request with no stall. Read misses and all stores hold `stall` high until main memory completes the transaction.

## Interface
- `LINES`, 16: number of one-word lines; power of two, ≥2.
- `IDX_W`, `$clog2(LINES)`: index width, derived.
- `clk` in 1: clock, all state on posedge.
- `reset_n` in 1: synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `dcache_addr` in 32: byte address; bits [1:0] ignored.
- `dcache_re` in 1: read request.
- `dcache_we` in 4: byte write mask; nonzero means store.
- `dcache_din` in 32: store data, already lane-aligned.
- `dcache_dout` out 32: read data (registered).
- `stall` out 1: pipeline stall.
- `mem_req_valid` out 1: memory request valid.
- `mem_req_ready` in 1: memory accepts request.
- `mem_req_rw` out 1: 1 = write, 0 = read.
- `mem_req_addr` out 32: word-aligned address ([1:0] = 0).
- `mem_req_data` out 32: write data.
- `mem_req_mask` out 4: write byte mask; 0 on reads.
- `mem_resp_valid` in 1: read data valid, one cycle.
- `mem_resp_data` in 32: read data.

## Operation
- Address split: index = `addr[2+IDX_W-1:2]`, tag = `addr[31:2+IDX_W]`. Each line holds valid, tag and 32-bit data.
- Requests are sampled only on an edge where state is IDLE (`stall`=0). Inputs are ignored while `stall`=1. The cache latches addr, data and mask, so the core need not hold them.
- `we`≠0 takes priority over `re`. Both idle means no operation, and `dcache_dout` holds its value.
- **States:** IDLE, RD_REQ, RD_WAIT, WR_REQ.
- **Read hit** (IDLE): `dcache_dout` ← line data. Stay in IDLE.
- **Read miss** (IDLE) → RD_REQ.
  - In RD_REQ: `mem_req_valid`=1, `rw`=0, `mask`=0. Move to RD_WAIT on the edge where `mem_req_ready`=1.
  - In RD_WAIT: on `mem_resp_valid`, fill the line (valid=1, tag, data), set `dcache_dout` ← `mem_resp_data`, and return to IDLE.
- **Store** (IDLE) → WR_REQ.
  - If it hits, merge the masked byte lanes of `din` into the line during the same edge. A miss leaves the array unchanged (no allocate).
  - In WR_REQ: `mem_req_valid`=1, `rw`=1, with the latched addr, data and mask. Return to IDLE on `mem_req_ready`.
- `stall` = (state ≠ IDLE), decoded from registered state.
- `mem_resp_valid` outside RD_WAIT is ignored.
- **Reset:**
  - All valid bits = 0, state = IDLE.
  - `stall`=0, `dcache_dout`=0, `mem_req_valid`=0, `mem_req_rw`=0, `mem_req_addr`=0, `mem_req_data`=0, `mem_req_mask`=0.
  - A reset mid-transaction abandons it. A late response after reset is ignored.
  - Data and tag contents need not be reset.

## Timing
- A request sampled at edge N:
  - read hit: data valid after N, `stall`=0 throughout;
  - read miss: `stall`=1 from N+1;
  - store: `stall`=1 from N+1.
- Read miss, with the request accepted at edge A and the response arriving at edge R (R > A): `stall` falls and `dcache_dout` is valid after R. Minimum miss penalty is 2 stall cycles.
- Store accepted at edge A: `stall` falls after A. Minimum store penalty is 1 stall cycle. There is no write-response wait.
- `mem_req_*` outputs are registered and stable while `mem_req_valid`=1 and `mem_req_ready`=0.
- A miss fill followed by a read of the same address in the next IDLE cycle hits.

## Structure
- Package `dcache_pkg`: state enum (IDLE, RD_REQ, RD_WAIT, WR_REQ) and the byte-merge function (old, new, mask → merged).
- Sub-module `dcache_line_store`:
  - flop array of valid/tag/data;
  - one combinational lookup port (hit, data);
  - one write port (fill, or masked merge);
  - synchronous active-low valid clear.
- `dcache_ctrl` contains only the FSM, the request latch and the output registers.

## Test plan
- **Reset:** hold `reset_n`=0 for 2 cycles with `re`=1 → `stall`=0, `dcache_dout`=0, `mem_req_valid`=0. Then read 0x100 → miss.
- **Cold read miss then hit:** read 0x100, `ready` on the first request cycle, response 0xDEADBEEF three cycles later → `stall` high for 4 cycles, then `dout`=0xDEADBEEF. A reread of 0x100 returns 0xDEADBEEF with `stall`=0 and no `mem_req_valid`.
- **Conflict eviction:** with `LINES`=16, read 0x100 and then 0x140 (same index, different tag) → both miss. A reread of 0x100 misses again.
- **Store-byte hit:** line 0x100 = 0xDEADBEEF, store `we`=0b0010, `din`=0x0000AA00:
  - `mem_req` shows rw=1, addr=0x100, mask=0b0010, data=0x0000AA00;
  - a following read returns 0xDEADAAEF.
- **Store miss, no allocate:** store `we`=0xF to 0x200 → one write request. A following read of 0x200 issues a read request.
- **Backpressure and reset:**
  - With `mem_req_ready` low for 5 cycles, the `mem_req_*` outputs stay stable and `stall` stays 1.
  - Asserting reset in RD_WAIT, then pulsing `mem_resp_valid`, leaves `dout`=0 and the line invalid.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and helpers for the direct-mapped write-through
// data cache.
//   state_e    - controller FSM states
//   byte_merge - overlays the masked byte lanes of a new word onto an old word
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WR_REQ  = 2'd3
  } state_e;

  // Lane b of the result comes from new_word when mask[b] is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  mask);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) begin
        merged[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        merged[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// dcache_if: single-outstanding main-memory request/response bus.
//   master - cache side: drives the request, receives ready and read response
//   slave  - memory side
interface dcache_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rw;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/dcache_line_store.sv
// dcache_line_store: flop array of LINES one-word lines (valid, tag, data).
//   clk, reset_n      - clock, synchronous active-low clear of the valid bits
//   lk_idx, lk_tag    - combinational lookup; lk_hit / lk_data reflect the line
//   wr_en, wr_idx,
//   wr_tag, wr_data,
//   wr_mask           - write port: sets valid, stores tag, merges masked lanes
//                       (a fill uses mask 4'hF)
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             lk_hit,
  output logic [31:0]      lk_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_mask
);

  logic [LINES-1:0] valid_r;
  logic [TAG_W-1:0] tag_r  [LINES];
  logic [31:0]      data_r [LINES];

  assign lk_hit  = valid_r[lk_idx] && (tag_r[lk_idx] == lk_tag);
  assign lk_data = data_r[lk_idx];

  // Valid bits: the only state that reset has to clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_r <= {LINES{1'b0}};
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and data payload; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_r[wr_idx]  <= wr_tag;
      data_r[wr_idx] <= byte_merge(data_r[wr_idx], wr_data, wr_mask);
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: blocking, direct-mapped, write-through, no-write-allocate data
// cache controller.
//   clk, reset_n  - clock, synchronous active-low reset
//   dcache_addr   - byte address from the core ([1:0] ignored)
//   dcache_re     - read request
//   dcache_we     - byte write mask, nonzero = store (wins over dcache_re)
//   dcache_din    - lane-aligned store data
//   dcache_dout   - registered read data
//   stall         - high while a miss or store is in flight
//   mem           - main-memory request/response bus (master side)
// The mem_req_* registers double as the request latch: the fill after a read
// miss takes its index and tag from mem_req_addr.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall,
  dcache_if.master    mem
);

  localparam int TAG_W = 30 - IDX_W;

  state_e           state_r;
  state_e           state_nxt_s;
  logic [31:0]      dout_r;
  logic             req_valid_r;
  logic             req_rw_r;
  logic [31:0]      req_addr_r;
  logic [31:0]      req_data_r;
  logic [3:0]       req_mask_r;

  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic             lk_hit_s;
  logic [31:0]      lk_data_s;
  logic             is_store_s;
  logic             wr_en_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [TAG_W-1:0] wr_tag_s;
  logic [31:0]      wr_data_s;
  logic [3:0]       wr_mask_s;
  logic             unused_s;

  assign lk_idx_s   = dcache_addr[2 +: IDX_W];
  assign lk_tag_s   = dcache_addr[31 -: TAG_W];
  assign is_store_s = |dcache_we;
  assign unused_s   = ^dcache_addr[1:0];

  assign stall             = (state_r != ST_IDLE);
  assign dcache_dout       = dout_r;
  assign mem.mem_req_valid = req_valid_r;
  assign mem.mem_req_rw    = req_rw_r;
  assign mem.mem_req_addr  = req_addr_r;
  assign mem.mem_req_data  = req_data_r;
  assign mem.mem_req_mask  = req_mask_r;

  dcache_line_store #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_line_store (
    .clk     (clk),
    .reset_n (reset_n),
    .lk_idx  (lk_idx_s),
    .lk_tag  (lk_tag_s),
    .lk_hit  (lk_hit_s),
    .lk_data (lk_data_s),
    .wr_en   (wr_en_s),
    .wr_idx  (wr_idx_s),
    .wr_tag  (wr_tag_s),
    .wr_data (wr_data_s),
    .wr_mask (wr_mask_s)
  );

  // Next-state decode and line-store write port steering.
  always_comb begin
    state_nxt_s = state_r;
    wr_en_s     = 1'b0;
    wr_idx_s    = req_addr_r[2 +: IDX_W];
    wr_tag_s    = req_addr_r[31 -: TAG_W];
    wr_data_s   = mem.mem_resp_data;
    wr_mask_s   = 4'hF;
    case (state_r)
      ST_IDLE: begin
        if (is_store_s) begin
          // Store hit updates the line on the same edge; a miss never allocates.
          state_nxt_s = ST_WR_REQ;
          wr_en_s     = lk_hit_s;
          wr_idx_s    = lk_idx_s;
          wr_tag_s    = lk_tag_s;
          wr_data_s   = dcache_din;
          wr_mask_s   = dcache_we;
        end else if (dcache_re) begin
          state_nxt_s = lk_hit_s ? ST_IDLE : ST_RD_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        if (mem.mem_req_ready) begin
          state_nxt_s = ST_RD_WAIT;
        end else begin
          state_nxt_s = ST_RD_REQ;
        end
      end
      ST_RD_WAIT: begin
        if (mem.mem_resp_valid) begin
          state_nxt_s = ST_IDLE;
          wr_en_s     = 1'b1;
        end else begin
          state_nxt_s = ST_RD_WAIT;
        end
      end
      ST_WR_REQ: begin
        if (mem.mem_req_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WR_REQ;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Read data, request latch and registered memory-request outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout_r      <= 32'h0000_0000;
      req_valid_r <= 1'b0;
      req_rw_r    <= 1'b0;
      req_addr_r  <= 32'h0000_0000;
      req_data_r  <= 32'h0000_0000;
      req_mask_r  <= 4'h0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (is_store_s) begin
            req_valid_r <= 1'b1;
            req_rw_r    <= 1'b1;
            req_addr_r  <= {dcache_addr[31:2], 2'b00};
            req_data_r  <= dcache_din;
            req_mask_r  <= dcache_we;
          end else if (dcache_re) begin
            if (lk_hit_s) begin
              dout_r <= lk_data_s;
            end else begin
              req_valid_r <= 1'b1;
              req_rw_r    <= 1'b0;
              req_addr_r  <= {dcache_addr[31:2], 2'b00};
              req_data_r  <= 32'h0000_0000;
              req_mask_r  <= 4'h0;
            end
          end
        end
        ST_RD_REQ, ST_WR_REQ: begin
          if (mem.mem_req_ready) begin
            req_valid_r <= 1'b0;
          end
        end
        ST_RD_WAIT: begin
          if (mem.mem_resp_valid) begin
            dout_r <= mem.mem_resp_data;
          end
        end
        default: begin
          req_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed self-checking bench for dcache_ctrl. The bench acts
// as main memory, inserting ready/response delays given per operation, and
// compares outputs against hand-computed values.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] dcache_addr;
  logic        dcache_re;
  logic [3:0]  dcache_we;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic        stall;

  dcache_if mem_bus ();

  dcache_ctrl #(.LINES(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dcache_addr (dcache_addr),
    .dcache_re   (dcache_re),
    .dcache_we   (dcache_we),
    .dcache_din  (dcache_din),
    .dcache_dout (dcache_dout),
    .stall       (stall),
    .mem         (mem_bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          stall_cnt;
  int          req_cnt;
  logic        stable_ok;
  logic        cap_rw;
  logic [31:0] cap_addr;
  logic [31:0] cap_data;
  logic [3:0]  cap_mask;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, then play memory until stall drops (bounded).
  task automatic mem_op(input logic [31:0] addr, input logic re, input logic [3:0] we,
                        input logic [31:0] din, input int rdy_wait, input int resp_wait,
                        input logic [31:0] rdata);
    int wcnt;
    int rcnt;
    int cyc;
    dcache_addr = addr;
    dcache_re   = re;
    dcache_we   = we;
    dcache_din  = din;
    tick();
    dcache_addr = 32'hFFFF_FFFF;
    dcache_re   = 1'b0;
    dcache_we   = 4'h0;
    dcache_din  = 32'h0000_0000;
    stall_cnt = 0;
    req_cnt   = 0;
    stable_ok = 1'b1;
    wcnt = 0;
    rcnt = 0;
    cyc  = 0;
    while (stall === 1'b1 && cyc < 60) begin
      cyc++;
      stall_cnt++;
      if (mem_bus.mem_req_valid === 1'b1) begin
        if (wcnt == 0) begin
          cap_rw   = mem_bus.mem_req_rw;
          cap_addr = mem_bus.mem_req_addr;
          cap_data = mem_bus.mem_req_data;
          cap_mask = mem_bus.mem_req_mask;
        end else if (cap_rw !== mem_bus.mem_req_rw || cap_addr !== mem_bus.mem_req_addr ||
                     cap_data !== mem_bus.mem_req_data || cap_mask !== mem_bus.mem_req_mask) begin
          stable_ok = 1'b0;
        end
        mem_bus.mem_req_ready  = (wcnt == rdy_wait);
        if (wcnt == rdy_wait) req_cnt++;
        wcnt++;
        mem_bus.mem_resp_valid = 1'b0;
      end else begin
        mem_bus.mem_req_ready  = 1'b0;
        rcnt++;
        mem_bus.mem_resp_valid = (rcnt == resp_wait);
        mem_bus.mem_resp_data  = (rcnt == resp_wait) ? rdata : 32'h0000_0000;
      end
      tick();
    end
    mem_bus.mem_req_ready  = 1'b0;
    mem_bus.mem_resp_valid = 1'b0;
    mem_bus.mem_resp_data  = 32'h0000_0000;
    check_val("stall_bound", {31'h0, stall}, 32'h0);
  endtask

  initial begin
    reset_n     = 1'b0;
    dcache_addr = 32'h0000_0100;
    dcache_re   = 1'b1;
    dcache_we   = 4'h0;
    dcache_din  = 32'h0000_0000;
    mem_bus.mem_req_ready  = 1'b0;
    mem_bus.mem_resp_valid = 1'b0;
    mem_bus.mem_resp_data  = 32'h0000_0000;

    // Reset held two cycles with a read pending.
    tick();
    tick();
    check_val("rst_stall", {31'h0, stall}, 32'h0);
    check_val("rst_dout", dcache_dout, 32'h0);
    check_val("rst_req_valid", {31'h0, mem_bus.mem_req_valid}, 32'h0);
    check_val("rst_req_addr", mem_bus.mem_req_addr, 32'h0);
    check_val("rst_req_mask", {28'h0, mem_bus.mem_req_mask}, 32'h0);
    reset_n   = 1'b1;
    dcache_re = 1'b0;
    tick();

    // Cold miss: ready on first request cycle, response three cycles later.
    mem_op(32'h0000_0100, 1'b1, 4'h0, 32'h0, 0, 3, 32'hDEAD_BEEF);
    check_val("cold_stall_cyc", stall_cnt, 32'd4);
    check_val("cold_req_cnt", req_cnt, 32'd1);
    check_val("cold_rw", {31'h0, cap_rw}, 32'h0);
    check_val("cold_addr", cap_addr, 32'h0000_0100);
    check_val("cold_mask", {28'h0, cap_mask}, 32'h0);
    check_val("cold_dout", dcache_dout, 32'hDEAD_BEEF);

    // Reread hits: no stall, no request.
    mem_op(32'h0000_0100, 1'b1, 4'h0, 32'h0, 0, 1, 32'h1111_1111);
    check_val("hit_stall_cyc", stall_cnt, 32'd0);
    check_val("hit_req_valid", {31'h0, mem_bus.mem_req_valid}, 32'h0);
    check_val("hit_dout", dcache_dout, 32'hDEAD_BEEF);

    // Idle cycles hold dout.
    tick();
    tick();
    check_val("idle_dout_hold", dcache_dout, 32'hDEAD_BEEF);

    // Conflict: 0x140 shares index 0, minimum miss penalty.
    mem_op(32'h0000_0140, 1'b1, 4'h0, 32'h0, 0, 1, 32'h1234_5678);
    check_val("conf_req_cnt", req_cnt, 32'd1);
    check_val("conf_stall_cyc", stall_cnt, 32'd2);
    check_val("conf_dout", dcache_dout, 32'h1234_5678);
    mem_op(32'h0000_0100, 1'b1, 4'h0, 32'h0, 0, 1, 32'hDEAD_BEEF);
    check_val("evict_req_cnt", req_cnt, 32'd1);
    check_val("evict_dout", dcache_dout, 32'hDEAD_BEEF);

    // Store byte 1 hit (address low bits ignored).
    mem_op(32'h0000_0102, 1'b0, 4'b0010, 32'h0000_AA00, 0, 1, 32'h0);
    check_val("st_stall_cyc", stall_cnt, 32'd1);
    check_val("st_req_cnt", req_cnt, 32'd1);
    check_val("st_rw", {31'h0, cap_rw}, 32'h1);
    check_val("st_addr", cap_addr, 32'h0000_0100);
    check_val("st_mask", {28'h0, cap_mask}, 32'h2);
    check_val("st_data", cap_data, 32'h0000_AA00);
    mem_op(32'h0000_0100, 1'b1, 4'h0, 32'h0, 0, 1, 32'h9999_9999);
    check_val("st_merge_req", req_cnt, 32'd0);
    check_val("st_merge_dout", dcache_dout, 32'hDEAD_AAEF);

    // Store miss does not allocate; store wins over a concurrent read.
    mem_op(32'h0000_0200, 1'b1, 4'hF, 32'hCAFE_F00D, 0, 1, 32'h0);
    check_val("stm_req_cnt", req_cnt, 32'd1);
    check_val("stm_rw", {31'h0, cap_rw}, 32'h1);
    check_val("stm_data", cap_data, 32'hCAFE_F00D);
    mem_op(32'h0000_0200, 1'b1, 4'h0, 32'h0, 0, 1, 32'h0BAD_F00D);
    check_val("stm_rd_req", req_cnt, 32'd1);
    check_val("stm_rd_rw", {31'h0, cap_rw}, 32'h0);
    check_val("stm_rd_dout", dcache_dout, 32'h0BAD_F00D);

    // Backpressure: ready low for 5 cycles.
    mem_op(32'h0000_0300, 1'b1, 4'h0, 32'h0, 5, 1, 32'h3030_3030);
    check_val("bp_rd_stall", stall_cnt, 32'd7);
    check_val("bp_rd_stable", {31'h0, stable_ok}, 32'h1);
    check_val("bp_rd_addr", cap_addr, 32'h0000_0300);
    check_val("bp_rd_dout", dcache_dout, 32'h3030_3030);
    mem_op(32'h0000_0304, 1'b0, 4'b1001, 32'hA500_005A, 5, 1, 32'h0);
    check_val("bp_st_stall", stall_cnt, 32'd6);
    check_val("bp_st_stable", {31'h0, stable_ok}, 32'h1);
    check_val("bp_st_mask", {28'h0, cap_mask}, 32'h9);

    // Reset while in RD_WAIT, then a late response.
    dcache_addr = 32'h0000_0400;
    dcache_re   = 1'b1;
    tick();
    dcache_re   = 1'b0;
    check_val("rw_req_valid", {31'h0, mem_bus.mem_req_valid}, 32'h1);
    mem_bus.mem_req_ready = 1'b1;
    tick();
    mem_bus.mem_req_ready = 1'b0;
    check_val("rw_wait_stall", {31'h0, stall}, 32'h1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_val("rw_rst_stall", {31'h0, stall}, 32'h0);
    mem_bus.mem_resp_valid = 1'b1;
    mem_bus.mem_resp_data  = 32'h5555_5555;
    tick();
    mem_bus.mem_resp_valid = 1'b0;
    mem_bus.mem_resp_data  = 32'h0000_0000;
    check_val("late_resp_dout", dcache_dout, 32'h0);
    check_val("late_resp_stall", {31'h0, stall}, 32'h0);
    mem_op(32'h0000_0400, 1'b1, 4'h0, 32'h0, 0, 1, 32'h6666_6666);
    check_val("post_rst_req", req_cnt, 32'd1);
    check_val("post_rst_dout", dcache_dout, 32'h6666_6666);
    mem_op(32'h0000_0300, 1'b1, 4'h0, 32'h0, 0, 1, 32'h7777_7777);
    check_val("post_rst_inval", req_cnt, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
